// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared palette indices, Q4.12 constant type and iteration normalisation
package gfx_pkg;

  localparam logic [1:0] PAL_GRAY  = 2'd0;
  localparam logic [1:0] PAL_FIRE  = 2'd1;
  localparam logic [1:0] PAL_OCEAN = 2'd2;
  localparam logic [1:0] PAL_INV   = 2'd3;

  localparam int Q_W = 16;
  typedef logic signed [Q_W-1:0] q4_12_t;

  // Bring an iteration count of any width onto an 8-bit scale: wide counts
  // keep their top byte, narrow counts are shifted up into the top bits.
  function automatic logic [7:0] iter_to_i8(input logic [31:0] iter, input int iter_w);
    logic [31:0] t;
    if (iter_w >= 8) t = iter >> (iter_w - 8);
    else             t = iter << (8 - iter_w);
    return t[7:0];
  endfunction

endpackage

// File: rtl/gfx_ctrl_if.sv
// rtl/gfx_ctrl_if.sv - pixel bus between timing/iteration core, colour stage and encoder
interface gfx_ctrl_if #(
  parameter int COORD_W = 16,
  parameter int ITER_W  = 8
);
  logic signed [COORD_W-1:0] i_x;
  logic signed [COORD_W-1:0] i_y;
  logic                      i_v_sync;
  logic [ITER_W-1:0]         i_iter;
  logic [7:0]                o_red;
  logic [7:0]                o_green;
  logic [7:0]                o_blue;

  modport master (
    output i_x, i_y, i_v_sync, i_iter,
    input  o_red, o_green, o_blue
  );

  modport slave (
    input  i_x, i_y, i_v_sync, i_iter,
    output o_red, o_green, o_blue
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stability counter and press pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then flip the debounced level only after the synchronised
  // input has differed from it for DEBOUNCE_CYC consecutive cycles; any
  // agreement in between restarts the count. Rising flips emit one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      o_press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level   <= sync2;
          cnt     <= '0;
          o_press <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gfx_ctrl.sv
// rtl/gfx_ctrl.sv - button-driven shadow registers committed at vsync and iteration-to-RGB palette pipeline
module gfx_ctrl
  import gfx_pkg::*;
#(
  parameter int COORD_W      = 16,
  parameter int H_RES        = 1280,
  parameter int V_RES        = 720,
  parameter int N_BTN        = 3,
  parameter int ITER_W       = 8,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int C_STEP       = 64,
  parameter int C_MIN        = -8192,
  parameter int C_MAX        = 8191,
  parameter int C_RE_INIT    = -3277,
  parameter int C_IM_INIT    = 2785
) (
  input  logic             clk,
  input  logic             rst,
  gfx_ctrl_if.slave        pix,
  input  logic [N_BTN-1:0] i_btn,
  output q4_12_t           o_c_re,
  output q4_12_t           o_c_im,
  output logic [1:0]       o_pal,
  output logic [15:0]      o_frame_cnt
);

  localparam int SUM_W = Q_W + 2;
  localparam logic signed [SUM_W-1:0]   C_STEP_S = SUM_W'(C_STEP);
  localparam logic signed [SUM_W-1:0]   C_MAX_S  = SUM_W'(C_MAX);
  localparam q4_12_t                    C_MIN_Q  = Q_W'(C_MIN);
  localparam q4_12_t                    C_RE_RST = Q_W'(C_RE_INIT);
  localparam q4_12_t                    C_IM_RST = Q_W'(C_IM_INIT);
  localparam logic signed [COORD_W-1:0] H_LIM    = COORD_W'(H_RES);
  localparam logic signed [COORD_W-1:0] V_LIM    = COORD_W'(V_RES);

  // One step up the Julia-constant ladder; overshooting the ceiling wraps to the floor.
  function automatic q4_12_t c_next(input q4_12_t c);
    logic signed [SUM_W-1:0] s;
    s = {{2{c[Q_W-1]}}, c} + C_STEP_S;
    if (s > C_MAX_S) return C_MIN_Q;
    return s[Q_W-1:0];
  endfunction

  logic [N_BTN-1:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (i_btn[gi]),
        .o_press (press[gi])
      );
    end
  endgenerate

  logic        vs_q;
  logic        vs_edge;
  logic [1:0]  pal_pend;
  logic [1:0]  pal_act;
  q4_12_t      c_re_pend;
  q4_12_t      c_re_act;
  q4_12_t      c_im_pend;
  q4_12_t      c_im_act;
  logic [15:0] frame_cnt;

  assign vs_edge = pix.i_v_sync & ~vs_q;

  // Presses edit the pending copies; vsync copies pending to active. Both use
  // pre-edge values, so a press in the commit cycle waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      pal_pend  <= PAL_GRAY;
      pal_act   <= PAL_GRAY;
      c_re_pend <= C_RE_RST;
      c_re_act  <= C_RE_RST;
      c_im_pend <= C_IM_RST;
      c_im_act  <= C_IM_RST;
      frame_cnt <= '0;
    end else begin
      vs_q <= pix.i_v_sync;
      if (press[0]) pal_pend  <= pal_pend + 2'd1;
      if (press[1]) c_re_pend <= c_next(c_re_pend);
      if (press[2]) c_im_pend <= c_next(c_im_pend);
      if (vs_edge) begin
        pal_act   <= pal_pend;
        c_re_act  <= c_re_pend;
        c_im_act  <= c_im_pend;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign o_pal       = pal_act;
  assign o_c_re      = c_re_act;
  assign o_c_im      = c_im_act;
  assign o_frame_cnt = frame_cnt;

  logic signed [COORD_W-1:0] x_s;
  logic signed [COORD_W-1:0] y_s;
  logic [ITER_W-1:0]         iter_s;
  logic                      blank;

  assign x_s    = pix.i_x;
  assign y_s    = pix.i_y;
  assign iter_s = pix.i_iter;
  assign blank  = (&iter_s) | x_s[COORD_W-1] | (x_s >= H_LIM)
                             | y_s[COORD_W-1] | (y_s >= V_LIM);

  logic [7:0] i8_q;
  logic       blank_q;
  logic [1:0] pal_q;

  // Stage 1: normalise the count, flag blanked pixels, capture the palette in use.
  always_ff @(posedge clk) begin
    if (rst) begin
      i8_q    <= '0;
      blank_q <= 1'b0;
      pal_q   <= PAL_GRAY;
    end else begin
      i8_q    <= iter_to_i8(32'(iter_s), ITER_W);
      blank_q <= blank;
      pal_q   <= pal_act;
    end
  end

  logic [7:0] r_n;
  logic [7:0] g_n;
  logic [7:0] b_n;

  // Palette lookup; fire doubles the lower half into red and the upper half into green.
  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (pal_q)
      PAL_GRAY: begin
        r_n = i8_q;
        g_n = i8_q;
        b_n = i8_q;
      end
      PAL_FIRE: begin
        r_n = i8_q[7] ? 8'hFF : {i8_q[6:0], 1'b0};
        g_n = i8_q[7] ? {i8_q[6:0], 1'b0} : 8'h00;
      end
      PAL_OCEAN: begin
        g_n = i8_q;
        b_n = 8'hFF - {1'b0, i8_q[7:1]};
      end
      default: begin
        r_n = ~i8_q;
        g_n = ~i8_q;
        b_n = ~i8_q;
      end
    endcase
    if (blank_q) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // Stage 2: register the colour towards the encoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix.o_red   <= '0;
      pix.o_green <= '0;
      pix.o_blue  <= '0;
    end else begin
      pix.o_red   <= r_n;
      pix.o_green <= g_n;
      pix.o_blue  <= b_n;
    end
  end

endmodule

// File: tb/tb_gfx_ctrl.sv
// tb/tb_gfx_ctrl.sv - self-checking bench for gfx_ctrl against a frame-level reference model
module tb_gfx_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn;
  logic signed [15:0] c_re;
  logic signed [15:0] c_im;
  logic [1:0]  pal;
  logic [15:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  int pal_pend_m, pal_act_m, c_re_pend_m, c_re_act_m, c_im_pend_m, c_im_act_m, frame_m;

  always #5 clk = ~clk;

  gfx_ctrl_if #(.COORD_W(16), .ITER_W(8)) pix ();

  gfx_ctrl #(.DEBOUNCE_CYC(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pix),
    .i_btn       (btn),
    .o_c_re      (c_re),
    .o_c_im      (c_im),
    .o_pal       (pal),
    .o_frame_cnt (frame_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic int c_next(input int c);
    return (c + 64 > 8191) ? -8192 : c + 64;
  endfunction

  function automatic logic [23:0] ref_rgb(input int p, input int x, input int y, input int it);
    int r, g, b;
    if (it == 255 || x < 0 || x >= 1280 || y < 0 || y >= 720) return 24'h0;
    case (p)
      0: begin r = it; g = it; b = it; end
      1: begin
        if (it < 128) begin r = 2 * it; g = 0; end
        else begin r = 255; g = 2 * (it - 128); end
        b = 0;
      end
      2: begin r = 0; g = it; b = 255 - it / 2; end
      default: begin r = 255 - it; g = 255 - it; b = 255 - it; end
    endcase
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic model_reset();
    pal_pend_m = 0; pal_act_m = 0;
    c_re_pend_m = -3277; c_re_act_m = -3277;
    c_im_pend_m = 2785;  c_im_act_m = 2785;
    frame_m = 0;
  endtask

  task automatic model_press(input int b);
    case (b)
      0: pal_pend_m = (pal_pend_m + 1) % 4;
      1: c_re_pend_m = c_next(c_re_pend_m);
      2: c_im_pend_m = c_next(c_im_pend_m);
      default: ;
    endcase
  endtask

  task automatic model_commit();
    pal_act_m = pal_pend_m;
    c_re_act_m = c_re_pend_m;
    c_im_act_m = c_im_pend_m;
    frame_m = (frame_m + 1) % 65536;
  endtask

  // Hold a raw button for 'hold' cycles then release long enough to settle.
  task automatic press_btn(input int b, input int hold);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
    tick(DB + 4);
    if (hold >= DB) model_press(b);
  endtask

  task automatic vs_pulse();
    pix.i_v_sync = 1'b1;
    tick();
    model_commit();
    pix.i_v_sync = 1'b0;
    tick();
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, "_c_re"},  c_re,      c_re_act_m);
    chk({tag, "_c_im"},  c_im,      c_im_act_m);
    chk({tag, "_pal"},   pal,       pal_act_m);
    chk({tag, "_frame"}, frame_cnt, frame_m);
  endtask

  task automatic pix_check(input string tag, input int x, input int y, input int it);
    pix.i_x = 16'(x);
    pix.i_y = 16'(y);
    pix.i_iter = 8'(it);
    tick(2);
    chk(tag, {pix.o_red, pix.o_green, pix.o_blue}, ref_rgb(pal_act_m, x, y, it));
  endtask

  // Stream one random pixel per cycle; each colour is compared two cycles later.
  task automatic rand_pixels(input string tag, input int n);
    logic [23:0] q[$];
    int x, y, it;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, 1400)) - 60;
      y = int'($urandom_range(0, 800)) - 40;
      it = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
      pix.i_x = 16'(x);
      pix.i_y = 16'(y);
      pix.i_iter = 8'(it);
      q.push_back(ref_rgb(pal_act_m, x, y, it));
      tick();
      if (q.size() == 2) chk(tag, {pix.o_red, pix.o_green, pix.o_blue}, q.pop_front());
    end
    tick();
    chk(tag, {pix.o_red, pix.o_green, pix.o_blue}, q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    btn = '0;
    pix.i_x = '0;
    pix.i_y = '0;
    pix.i_iter = '0;
    pix.i_v_sync = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b0;
    check_ctrl("reset");
    chk("reset_rgb", {pix.o_red, pix.o_green, pix.o_blue}, 24'h0);

    pix_check("gray_40", 10, 10, 8'h40);
    chk("gray_40_const", {pix.o_red, pix.o_green, pix.o_blue}, 24'h404040);
    pix_check("inside_ff", 10, 10, 8'hFF);
    pix_check("x_eq_hres", 1280, 10, 8'h40);
    pix_check("x_last", 1279, 719, 8'h33);
    pix_check("x_neg", -1, 10, 8'h40);
    pix_check("y_eq_vres", 10, 720, 8'h40);

    press_btn(0, 2);
    vs_pulse();
    check_ctrl("glitch");

    press_btn(0, 10);
    check_ctrl("pend_only");
    vs_pulse();
    check_ctrl("pal_commit");
    pix_check("fire_a0", 10, 10, 8'hA0);
    chk("fire_a0_const", {pix.o_red, pix.o_green, pix.o_blue}, 24'hFF4000);
    rand_pixels("rand_fire", 40);

    press_btn(0, 6);
    vs_pulse();
    rand_pixels("rand_ocean", 40);
    press_btn(0, 6);
    vs_pulse();
    rand_pixels("rand_inv", 40);
    press_btn(0, 6);
    vs_pulse();
    check_ctrl("pal_wrap");
    rand_pixels("rand_gray", 40);

    // Press pulse lands in the same cycle as the vsync edge.
    btn[2] = 1'b1;
    tick(DB + 2);
    pix.i_v_sync = 1'b1;
    tick();
    model_commit();
    model_press(2);
    check_ctrl("coincide_edge");
    pix.i_v_sync = 1'b0;
    btn[2] = 1'b0;
    tick(DB + 4);
    check_ctrl("coincide_hold");
    vs_pulse();
    check_ctrl("coincide_next");
    chk("c_im_2849", c_im, 2849);

    for (int i = 0; i < 179; i++) press_btn(1, 5);
    vs_pulse();
    check_ctrl("c_re_top");
    press_btn(1, 5);
    vs_pulse();
    check_ctrl("c_re_wrap");
    chk("c_re_floor", c_re, -8192);

    // Reset in the middle of a debounce count must leave no press behind.
    btn[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick();
    model_reset();
    check_ctrl("mid_rst");
    chk("mid_rst_rgb", {pix.o_red, pix.o_green, pix.o_blue}, 24'h0);
    btn[0] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(DB + 6);
    vs_pulse();
    check_ctrl("no_spurious");

    // A button held through reset counts as one press after release.
    btn[0] = 1'b1;
    rst = 1'b1;
    tick(3);
    model_reset();
    rst = 1'b0;
    tick(DB + 4);
    btn[0] = 1'b0;
    tick(DB + 4);
    model_press(0);
    vs_pulse();
    check_ctrl("held_rst");
    rand_pixels("rand_after_rst", 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
